// File: rtl/mem_responder.sv
// Word-organised RAM responder for the CPU load/store path: req/ack handshake, wait states,
// byte-lane store merging and alignment checking. Optional macro: MEM_RESPONDER_LOAD_EXTRACT_EN.
module mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned AW    = ADDR_W + 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          ack_q, err_q;

  logic [31:0]   mem [Depth];

  logic          sel_wr;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]    lane;
  logic          illegal;
  logic          commit;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   raw_word;
  logic [31:0]   load_data;
  logic          mem_we;

  // Upper address bits wrap and are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW];

  // With zero wait states the commit happens on the accept edge, so use the live inputs.
  always_comb begin
    if (state_q == StIdle) begin
      sel_wr    = wr;
      sel_size  = size;
      sel_addr  = addr[AW-1:0];
      sel_wdata = wdata;
    end else begin
      sel_wr    = wr_q;
      sel_size  = size_q;
      sel_addr  = addr_q;
      sel_wdata = wdata_q;
    end
  end

  assign word_idx = sel_addr[AW-1:2];
  assign lane     = sel_addr[1:0];

  always_comb begin
    illegal = 1'b0;
    unique case (sel_size)
      2'b00: illegal = 1'b0;
      2'b01: illegal = lane[0];
      2'b10: illegal = (lane != 2'b00);
      2'b11: illegal = 1'b1;
    endcase
  end

  always_comb begin
    be = 4'b0000;
    wd = sel_wdata;
    unique case (sel_size)
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{sel_wdata[7:0]}};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{sel_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      2'b11: be = 4'b0000;
    endcase
  end

  assign raw_word = mem[word_idx];

`ifdef MEM_RESPONDER_LOAD_EXTRACT_EN
  logic [31:0] lane_shift;
  assign lane_shift = raw_word >> {lane, 3'b000};

  always_comb begin
    load_data = raw_word;
    unique case (sel_size)
      2'b00:   load_data = {24'h0, lane_shift[7:0]};
      2'b01:   load_data = {16'h0, lane[1] ? raw_word[31:16] : raw_word[15:0]};
      default: load_data = raw_word;
    endcase
  end
`else
  assign load_data = raw_word;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Gate with reset so a clock edge during reset can never write RAM.
  assign mem_we = commit & sel_wr & ~illegal & reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req) begin
        wr_q    <= wr;
        size_q  <= size;
        addr_q  <= addr[AW-1:0];
        wdata_q <= wdata;
      end
      ack_q <= commit;
      err_q <= commit & illegal;
      if (commit) begin
        if (illegal)      rdata_q <= 32'h0;
        else if (!sel_wr) rdata_q <= load_data;
      end
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with 0, 1 and 3 wait states share the
// request bus; each has its own req strobe and a bench-side RAM model.
module tb_mem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        req0, req1, req3;
  logic [31:0] rdata0, rdata1, rdata3;
  logic        ack0, ack1, ack3, err0, err1, err3, busy0, busy1, busy3;

  logic [31:0] s_rdata;
  logic        s_ack, s_err, s_busy;
  int          cur_sel;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [31:0] model [3][256];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
  );
  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1)
  );
  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .ack(ack3), .err(err3), .busy(busy3)
  );

  always_comb begin
    s_rdata = rdata1;
    s_ack   = ack1;
    s_err   = err1;
    s_busy  = busy1;
    case (cur_sel)
      0: begin s_rdata = rdata0; s_ack = ack0; s_err = err0; s_busy = busy0; end
      2: begin s_rdata = rdata3; s_ack = ack3; s_err = err3; s_busy = busy3; end
      default: ;
    endcase
  end

  function automatic int lat(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit legal(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'b00:   return 1'b1;
      2'b01:   return a[0] == 1'b0;
      2'b10:   return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] expect_load(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [31:0] a);
`ifdef MEM_RESPONDER_LOAD_EXTRACT_EN
    logic [31:0] tmp;
    tmp = word >> (8 * int'(a[1:0]));
    if (sz == 2'b00) return {24'h0, tmp[7:0]};
    if (sz == 2'b01) return a[1] ? {16'h0, word[31:16]} : {16'h0, word[15:0]};
    return word;
`else
    if (sz == 2'b11) return 32'h0;
    return word;
`endif
  endfunction

  task automatic set_req(input int k, input logic v);
    case (k)
      0:       req0 = v;
      1:       req1 = v;
      default: req3 = v;
    endcase
  endtask

  // One full transaction on instance k: predict, drive, wait for ack (bounded), compare.
  task automatic xact(input int k, input bit w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input string name);
    exp_t        e;
    logic [31:0] word;
    int          idx;
    int          edges;
    bit          seen;
    idx    = int'(a[9:2]);
    word   = model[k][idx];
    e.err  = 1'b0;
    e.rdata = 32'h0;
    e.chk  = 1'b1;
    if (!legal(sz, a)) begin
      e.err = 1'b1;
    end else if (w) begin
      case (sz)
        2'b00:   word[8*int'(a[1:0]) +: 8] = d[7:0];
        2'b01:   if (a[1]) word[31:16] = d[15:0]; else word[15:0] = d[15:0];
        default: word = d;
      endcase
      model[k][idx] = word;
      e.chk = 1'b0;
    end else begin
      e.rdata = expect_load(word, sz, a);
    end
    sb.push_back(e);
    cur_sel = k;
    @(negedge clk);
    wr = w; size = sz; addr = a; wdata = d;
    set_req(k, 1'b1);
    seen  = 1'b0;
    edges = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      edges = i;
      if (s_ack === 1'b1) seen = 1'b1;
    end
    set_req(k, 1'b0);
    e = sb.pop_front();
    checks++;
    if (!seen || edges != lat(k)) begin
      failures++;
      $display("FAIL %s latency: got %0d edges (ack seen %0b), expected %0d", name, edges, seen,
               lat(k));
    end
    checks++;
    if (s_err !== e.err) begin
      failures++;
      $display("FAIL %s err: got %b, expected %b", name, s_err, e.err);
    end
    if (e.chk) begin
      checks++;
      if (s_rdata !== e.rdata) begin
        failures++;
        $display("FAIL %s rdata: got %h, expected %h", name, s_rdata, e.rdata);
      end
    end
    @(negedge clk);
    checks++;
    if (s_ack !== 1'b0 || s_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s ack_pulse: got ack=%b busy=%b, expected 0 0", name, s_ack, s_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0; req3 = 1'b0;
    wr = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0;
    cur_sel = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack0, ack1, ack3, err0, err1, err3, busy0, busy1, busy3} !== 9'h0 ||
        {rdata0, rdata1, rdata3} !== 96'h0) begin
      failures++;
      $display("FAIL reset_outputs: got ack=%b%b%b err=%b%b%b busy=%b%b%b, expected all 0",
               ack0, ack1, ack3, err0, err1, err3, busy0, busy1, busy3);
    end
    reset = 1'b1;
  endtask

  task automatic test_word_rw();
    xact(1, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, "word_store");
    xact(1, 1'b0, 2'b10, 32'h10, 32'h0, "word_load");
  endtask

  task automatic test_lane_merge();
    xact(1, 1'b1, 2'b10, 32'h10, 32'h11223344, "merge_init");
    xact(1, 1'b1, 2'b00, 32'h12, 32'h000000AA, "byte_store");
    xact(1, 1'b1, 2'b01, 32'h10, 32'h00005555, "half_store");
    xact(1, 1'b0, 2'b10, 32'h10, 32'h0, "merge_load");
    checks++;
    if (model[1][4] !== 32'h11AA5555) begin
      failures++;
      $display("FAIL merge_model: got %h, expected 11aa5555", model[1][4]);
    end
    xact(1, 1'b1, 2'b00, 32'h17, 32'h000000C3, "byte_lane3");
    xact(1, 1'b1, 2'b01, 32'h16, 32'h00009876, "half_upper");
    xact(1, 1'b0, 2'b00, 32'h15, 32'h0, "byte_load");
  endtask

  task automatic test_misaligned();
    xact(1, 1'b1, 2'b10, 32'h20, 32'h01020304, "mis_init");
    xact(1, 1'b1, 2'b10, 32'h21, 32'hFFFFFFFF, "word_misaligned");
    xact(1, 1'b0, 2'b10, 32'h20, 32'h0, "mis_unchanged");
    xact(1, 1'b0, 2'b01, 32'h23, 32'h0, "half_misaligned");
    xact(1, 1'b1, 2'b11, 32'h20, 32'h0BADBEEF, "size11_store");
    xact(1, 1'b0, 2'b11, 32'h20, 32'h0, "size11_load");
    xact(1, 1'b0, 2'b10, 32'h20, 32'h0, "size11_unchanged");
  endtask

  task automatic test_back_to_back();
    int accepts;
    accepts = 0;
    cur_sel = 0;
    @(negedge clk);
    wr = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h0BADCAFE;
    req0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack0 === 1'b1) accepts++;
      checks++;
      if (ack0 !== i[0] || busy0 !== i[0] || err0 !== 1'b0) begin
        failures++;
        $display("FAIL b2b_cycle%0d: got ack=%b busy=%b err=%b, expected %b %b 0", i, ack0,
                 busy0, err0, i[0], i[0]);
      end
    end
    req0 = 1'b0;
    model[0][16] = 32'h0BADCAFE;
    checks++;
    if (accepts != 4) begin
      failures++;
      $display("FAIL b2b_accepts: got %0d, expected 4", accepts);
    end
    xact(0, 1'b0, 2'b10, 32'h40, 32'h0, "b2b_load");
  endtask

  task automatic test_reset_abort();
    int stray;
    xact(2, 1'b1, 2'b10, 32'h30, 32'h12345678, "abort_init");
    xact(2, 1'b0, 2'b10, 32'h30, 32'h0, "abort_preload");
    cur_sel = 2;
    @(negedge clk);
    wr = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'hCAFEF00D;
    req3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy3 !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy: got %b, expected 1", busy3);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    req3 = 1'b0;
    #1;
    checks++;
    if (ack3 !== 1'b0 || busy3 !== 1'b0 || err3 !== 1'b0 || rdata3 !== 32'h0) begin
      failures++;
      $display("FAIL abort_outputs: got ack=%b busy=%b err=%b rdata=%h, expected 0 0 0 0",
               ack3, busy3, err3, rdata3);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack3 !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL abort_no_ack: got %0d ack cycles, expected 0", stray);
    end
    xact(2, 1'b0, 2'b10, 32'h30, 32'h0, "abort_old_value");
  endtask

  task automatic test_wrap();
    xact(1, 1'b1, 2'b10, 32'h400, 32'hAABBCCDD, "wrap_store");
    xact(1, 1'b0, 2'b10, 32'h000, 32'h0, "wrap_load");
    xact(1, 1'b0, 2'b00, 32'h403, 32'h0, "wrap_byte_load");
    xact(1, 1'b0, 2'b01, 32'h402, 32'h0, "wrap_half_load");
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_lane_merge();
    test_misaligned();
    test_back_to_back();
    test_reset_abort();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
